// File: rtl/tri_bus_arb_pkg.sv
// Shared types and constant helpers for the tristate bus arbiter.
// Latency: none (types and elaboration-time functions only).
// Backpressure: not applicable.
package tri_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // Ceiling log2, evaluated at elaboration time.
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    // Turnaround counter width; holds values 0..ta-1, never narrower than 1 bit.
    function automatic int ta_cnt_w(input int ta);
        return (clog2(ta) < 1) ? 1 : clog2(ta);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: first set request at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: none; vld is simply |req.
//
// Ports:
//   req  - request vector
//   ptr  - highest-priority index this round
//   vld  - some request is set
//   win  - winning index (only meaningful when vld=1)
module rr_pick
    import tri_bus_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]        req,
    input  logic [clog2(NREQ)-1:0] ptr,
    output logic                   vld,
    output logic [clog2(NREQ)-1:0] win
);

    localparam int IW = clog2(NREQ);

    logic [NREQ-1:0] rot;
    logic [IW-1:0]   k;
    logic [IW:0]     sum;

    always_comb begin
        // Rotate so that bit ptr lands at position 0.
        rot = NREQ'({req, req} >> ptr);
        // Lowest set bit of the rotated vector wins.
        k = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                k = IW'(i);
            end
        end
        // Undo the rotation, modulo NREQ (which need not be a power of two).
        sum = {1'b0, k} + {1'b0, ptr};
        if (sum >= (IW + 1)'(NREQ)) begin
            sum = sum - (IW + 1)'(NREQ);
        end
        vld = |req;
        win = sum[IW-1:0];
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner sequencer for a shared tristate bus with all-released turnaround gaps.
// Latency: request to grant 1 cycle from idle; owner release to next grant TA_CYCLES+1 cycles.
// Backpressure: level requests are held off until the bus is idle or the last turnaround cycle.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (drops all drive enables at once)
//   req        - per-requester level request
//   gnt, oe    - registered one-hot-or-zero grant / driver enable (identical)
//   owner      - index of current owner, holds last value while idle
//   bus_busy   - any grant bit set
//   ta_active  - turnaround cycle, no driver enabled
//   preempt    - one-cycle pulse when the hold limit ends a grant
//
// Build option: define TRI_BUS_ARB_HOLD_LIMIT_EN to cap a grant at HOLD_MAX
// consecutive cycles; otherwise a grant lasts as long as its request.
module tri_bus_arbiter
    import tri_bus_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int TA_CYCLES = 1,
    parameter int HOLD_MAX  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        oe,
    output logic [clog2(NREQ)-1:0] owner,
    output logic                   bus_busy,
    output logic                   ta_active,
    output logic                   preempt
);

    localparam int IW = clog2(NREQ);
    localparam int TW = ta_cnt_w(TA_CYCLES);

    if (NREQ < 2 || NREQ > 16 || TA_CYCLES < 1 || HOLD_MAX < 1) begin : g_bad_param
        $error("tri_bus_arbiter: parameter out of range");
    end

    arb_state_t    state;
    logic [IW-1:0] ptr;
    logic [TW-1:0] ta_cnt;

    logic          pick_vld;
    logic [IW-1:0] pick_win;
    logic          hold_hit;
    logic          arb_point;
    logic          grant_now;
    logic          release_now;

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req(req),
        .ptr(ptr),
        .vld(pick_vld),
        .win(pick_win)
    );

    // Requests are only looked at while idle or on the final turnaround cycle.
    assign arb_point   = (state == IDLE) || ((state == TURN) && (ta_cnt == '0));
    assign grant_now   = arb_point && pick_vld;
    assign release_now = (state == GRANT) && (!req[owner] || hold_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            ptr       <= '0;
            ta_cnt    <= '0;
            ta_active <= 1'b0;
        end else if (grant_now) begin
            state     <= GRANT;
            gnt       <= NREQ'(1) << pick_win;
            owner     <= pick_win;
            ptr       <= (pick_win == IW'(NREQ - 1)) ? '0 : pick_win + IW'(1);
            ta_active <= 1'b0;
        end else if (release_now) begin
            state     <= TURN;
            gnt       <= '0;
            ta_cnt    <= TW'(TA_CYCLES - 1);
            ta_active <= 1'b1;
        end else if (state == TURN) begin
            if (ta_cnt == '0) begin
                state     <= IDLE;
                ta_active <= 1'b0;
            end else begin
                ta_cnt <= ta_cnt - TW'(1);
            end
        end
    end

`ifdef TRI_BUS_ARB_HOLD_LIMIT_EN
    localparam int HW = clog2(HOLD_MAX + 1);

    logic [HW-1:0] hold_cnt;

    assign hold_hit = (hold_cnt == HW'(HOLD_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            // A release with the request still up can only be the hold limit.
            preempt <= release_now && req[owner];
            if (grant_now) begin
                hold_cnt <= HW'(1);
            end else if ((state == GRANT) && !hold_hit) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end
`else
    assign hold_hit = 1'b0;
    assign preempt  = 1'b0;
`endif

    assign oe       = gnt;
    assign bus_busy = |gnt;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
module tb_tri_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int TA       = 2;
    localparam int HOLD_MAX = 4;
`ifdef TRI_BUS_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0;
    logic [3:0] gnt;
    logic [3:0] oe;
    logic [1:0] owner;
    logic       bus_busy;
    logic       ta_active;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    tri_bus_arbiter #(
        .NREQ(NREQ),
        .TA_CYCLES(TA),
        .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .gnt(gnt),
        .oe(oe),
        .owner(owner),
        .bus_busy(bus_busy),
        .ta_active(ta_active),
        .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = nobody), turnaround cycles left,
    // next-priority index, cycles held so far.
    int m_own  = -1;
    int m_last = 0;
    int m_ptr  = 0;
    int m_ta   = 0;
    int m_hold = 0;
    bit m_pre  = 1'b0;

    task automatic m_arb();
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (req[idx]) begin
                m_own  = idx;
                m_last = idx;
                m_ptr  = (idx + 1) % NREQ;
                m_hold = 1;
                return;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = -1; m_last = 0; m_ptr = 0; m_ta = 0; m_hold = 0; m_pre = 1'b0;
        end else begin
            m_pre = 1'b0;
            if (m_own >= 0) begin
                if (!req[m_own]) begin
                    m_own = -1; m_ta = TA;
                end else if (HOLD_EN && m_hold >= HOLD_MAX) begin
                    m_own = -1; m_ta = TA; m_pre = 1'b1;
                end else begin
                    m_hold++;
                end
            end else if (m_ta > 1) begin
                m_ta--;
            end else begin
                m_ta = 0;
                m_arb();
            end
        end
    end

    function automatic logic [3:0] exp_gnt();
        return (m_own >= 0) ? (4'b1 << m_own) : 4'b0;
    endfunction

    logic [3:0] prev_oe = 4'b0;

    always @(negedge clk) begin
        chk("cmp_gnt", 32'(gnt), 32'(exp_gnt()));
        chk("cmp_oe", 32'(oe), 32'(exp_gnt()));
        chk("cmp_owner", 32'(owner), 32'(m_last));
        chk("cmp_busy", 32'(bus_busy), 32'(m_own >= 0));
        chk("cmp_ta", 32'(ta_active), 32'(m_ta > 0));
        chk("cmp_preempt", 32'(preempt), 32'(m_pre));
        chk("oe_onehot0", 32'($countones(oe) <= 1), 1);
        if (prev_oe != 4'b0 && oe != 4'b0)
            chk("no_overlap", 32'(oe), 32'(prev_oe));
        prev_oe = oe;
    end

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        // Reset state.
        repeat (3) at_edge();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(bus_busy), 0);
        chk("rst_ta", 32'(ta_active), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_preempt", 32'(preempt), 0);
        rst_n = 1'b1;
        at_edge(); at_edge();
        chk("idle_gnt", 32'(gnt), 0);

        // Single request from idle: granted on the next edge.
        req = 4'b0010;
        at_edge();
        chk("t1_gnt", 32'(gnt), 32'h2);
        chk("t1_oe", 32'(oe), 32'h2);
        chk("t1_owner", 32'(owner), 1);
        chk("t1_busy", 32'(bus_busy), 1);

        // Handover 1 -> 3 with two turnaround cycles.
        req = 4'b1010;
        at_edge(); at_edge();
        chk("t2_hold", 32'(gnt), 32'h2);
        req = 4'b1000;
        at_edge();
        chk("t2_ta1_oe", 32'(oe), 0);
        chk("t2_ta1", 32'(ta_active), 1);
        at_edge();
        chk("t2_ta2_oe", 32'(oe), 0);
        chk("t2_ta2", 32'(ta_active), 1);
        at_edge();
        chk("t2_gnt", 32'(gnt), 32'h8);
        chk("t2_owner", 32'(owner), 3);
        chk("t2_ta_off", 32'(ta_active), 0);
        req = 4'b0000;
        repeat (4) at_edge();
        chk("t2_idle", 32'(bus_busy), 0);
        chk("t2_owner_hold", 32'(owner), 3);

        // All requesting: owners rotate 0,1,2,3,0.
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int w = 0; w < 10; w++) begin
                at_edge();
                if (bus_busy) break;
            end
            chk("rot_wait", 32'(bus_busy), 1);
            chk("rot_owner", 32'(owner), 32'(g % 4));
            at_edge();
            req = 4'b1111 & ~(4'b1 << owner);
            at_edge();
            req = (g == 4) ? 4'b0000 : 4'b1111;
        end
        repeat (4) at_edge();

        // Asynchronous reset mid-grant.
        req = 4'b0100;
        at_edge();
        chk("t4_gnt", 32'(gnt), 32'h4);
        chk("t4_owner", 32'(owner), 2);
        at_edge();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_arst_oe", 32'(oe), 0);
        chk("t4_arst_busy", 32'(bus_busy), 0);
        at_edge(); at_edge();
        req   = 4'b1001;
        rst_n = 1'b1;
        at_edge();
        chk("t4_regrant", 32'(gnt), 32'h1);
        chk("t4_owner0", 32'(owner), 0);
        req = 4'b0000;
        repeat (4) at_edge();

        // Lone requester held high.
        req = 4'b0001;
        at_edge();
        chk("t5_gnt", 32'(gnt), 32'h1);
        hi = 1;
`ifdef TRI_BUS_ARB_HOLD_LIMIT_EN
        for (int w = 0; w < 20; w++) begin
            at_edge();
            if (gnt == 4'b0001) hi++;
            else break;
        end
        chk("t5_hold_len", 32'(hi), 4);
        chk("t5_preempt", 32'(preempt), 1);
        chk("t5_ta", 32'(ta_active), 1);
        at_edge();
        chk("t5_preempt_off", 32'(preempt), 0);
        at_edge();
        chk("t5_regrant", 32'(gnt), 32'h1);
`else
        repeat (120) begin
            at_edge();
            if (gnt == 4'b0001) hi++;
        end
        chk("t5_hold_len", 32'(hi), 121);
        chk("t5_preempt", 32'(preempt), 0);
`endif
        req = 4'b0000;
        repeat (4) at_edge();
        chk("end_idle", 32'(bus_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
